// File: rtl/eff_tremolo_v2.sv
// eff_tremolo_v2: 3-stage LFO tremolo (triangle/square/saw, optional sine).
// Define EFF_TREMOLO_SINE_EN to build the quarter-wave sine ROM for wave_sel_i=2.
module eff_tremolo_v2 #(
  parameter int DATA_WIDTH  = 16,
  parameter int GAIN_WIDTH  = 8,
  parameter int PHASE_WIDTH = 24,
  parameter int RATE_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [RATE_WIDTH-1:0]        rate_i,
  input  logic [GAIN_WIDTH-1:0]        depth_i,
  input  logic [1:0]                   wave_sel_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic                         vld_i,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         vld_o
);

  localparam int L  = GAIN_WIDTH;
  localparam int P  = PHASE_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam logic [L:0] UNITY = {1'b1, {L{1'b0}}};

  logic [P-1:0] ph;
  logic [L:0]   t;
  logic         m;
  logic [L-1:0] f;
  logic [L-1:0] u;

  assign t = ph[P-1:P-L-1];
  assign m = t[L];
  assign f = t[L-1:0];

`ifdef EFF_TREMOLO_SINE_EN
  localparam int N = 2 ** (L - 1);

  function automatic logic [L-1:0] rom_val(input int k);
    real x, s, term;
    x = 3.14159265358979 * k / (2.0 * N);
    s = x;
    term = x;
    for (int i = 1; i < 10; i++) begin
      term = -term * x * x / ((2.0 * i) * (2.0 * i + 1.0));
      s = s + term;
    end
    return L'($rtoi(((2.0 ** L) - 1.0) * (0.5 + 0.5 * s) + 0.5));
  endfunction

  logic [L-1:0] rom [N];
  logic [1:0]   q;
  logic [L-2:0] k;
  logic [L-2:0] kr;
  logic [L-1:0] sine_u;

  for (genvar gk = 0; gk < N; gk++) begin : g_rom
    assign rom[gk] = rom_val(gk);
  end

  assign q  = t[L:L-1];
  assign k  = t[L-2:0];
  assign kr = ~k + (L-1)'(1);

  // Negative half mirrors the positive half: 2^L-1-x is ~x.
  always_comb begin
    sine_u = rom[k];
    case (q)
      2'd1: sine_u = (k == '0) ? '1 : rom[kr];
      2'd2: sine_u = (k == '0) ? rom[0] : ~rom[k];
      2'd3: sine_u = (k == '0) ? '0 : ~rom[kr];
      default: ;
    endcase
  end
`endif

  always_comb begin
    u = m ? ~f : f;
    case (wave_sel_i)
      2'd1: u = m ? '0 : '1;
      2'd3: u = ~f;
`ifdef EFF_TREMOLO_SINE_EN
      2'd2: u = sine_u;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)          ph <= '0;
    else if (!en)     ph <= '0;
    else if (vld_i)   ph <= ph + P'(rate_i);
  end

  logic signed [DW-1:0] d1, d2;
  logic                 v1, v2, en1;
  logic [L-1:0]         u1, dep1;
  logic [L:0]           g2;

  always_ff @(posedge clk) begin
    if (rst) begin
      d1   <= '0;
      v1   <= 1'b0;
      u1   <= '0;
      dep1 <= '0;
      en1  <= 1'b0;
    end else begin
      d1   <= data_i;
      v1   <= vld_i;
      u1   <= u;
      dep1 <= depth_i;
      en1  <= en;
    end
  end

  logic [L:0]   inv;
  logic [2*L:0] dprod;
  logic [L:0]   g_c;

  assign inv   = UNITY - {1'b0, u1};
  assign dprod = (2*L+1)'(dep1) * (2*L+1)'(inv);
  assign g_c   = en1 ? UNITY - dprod[2*L:L] : UNITY;

  always_ff @(posedge clk) begin
    if (rst) begin
      d2 <= '0;
      v2 <= 1'b0;
      g2 <= '0;
    end else begin
      d2 <= d1;
      v2 <= v1;
      g2 <= g_c;
    end
  end

  logic signed [DW+L+1:0] prod;
  logic                   unused_bits;

  assign prod = $signed({{(L+2){d2[DW-1]}}, d2})
              * $signed({{(DW+1){1'b0}}, g2});
  assign unused_bits = ^{prod[DW+L+1:DW+L], prod[L-1:0], dprod[L-1:0]};

  // Slicing above bit L is the floor arithmetic shift by L.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o <= '0;
      vld_o  <= 1'b0;
    end else begin
      data_o <= prod[DW+L-1:L];
      vld_o  <= v2;
    end
  end

endmodule

// File: tb/tb_eff_tremolo_v2.sv
// tb_eff_tremolo_v2: directed self-checking bench for eff_tremolo_v2.
// Default build expects wave 2 == triangle unless EFF_TREMOLO_SINE_EN is set.
module tb_eff_tremolo_v2;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [15:0]        rate_i;
  logic [7:0]         depth_i;
  logic [1:0]         wave_sel_i;
  logic signed [15:0] data_i;
  logic               vld_i;
  logic signed [15:0] data_o;
  logic               vld_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  eff_tremolo_v2 dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .rate_i     (rate_i),
    .depth_i    (depth_i),
    .wave_sel_i (wave_sel_i),
    .data_i     (data_i),
    .vld_i      (vld_i),
    .data_o     (data_o),
    .vld_o      (vld_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic e, input logic [15:0] r,
                       input logic [7:0] dep, input logic [1:0] w,
                       input logic signed [15:0] d);
    vld_i = v; en = e; rate_i = r; depth_i = dep; wave_sel_i = w; data_i = d;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 8'h0, 2'd0, 16'sh0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'h8000, 8'hff, 2'd0, 16'sh1234);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total_cnt++;
      if (vld_o !== 1'b0) $display("FAIL reset vld_o=%b exp=0", vld_o);
      else pass_cnt++;
      total_cnt++;
      if (data_o !== 16'sh0) $display("FAIL reset data_o=%h exp=0000", data_o);
      else pass_cnt++;
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 8'h0, 2'd0, 16'sh0);
  endtask

  task automatic test_bypass;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        total_cnt++;
        if (vld_o !== (i == 3)) $display("FAIL bypass_vld i=%0d vld_o=%b exp=%b", i, vld_o, i == 3);
        else pass_cnt++;
      end
      if (i == 3) begin
        total_cnt++;
        if (data_o !== 16'sh8000) $display("FAIL bypass_data data_o=%h exp=8000", data_o);
        else pass_cnt++;
      end
      if (i == 0) drive(1'b1, 1'b0, 16'h8000, 8'hff, 2'd1, 16'sh8000);
      else        drive(1'b0, 1'b0, 16'h8000, 8'hff, 2'd1, 16'sh0);
    end
  endtask

  task automatic test_depth0;
    for (int w = 0; w < 4; w++) begin
      do_reset();
      for (int i = 0; i < 13; i++) begin
        @(negedge clk);
        if (i >= 3) begin
          total_cnt++;
          if (vld_o !== 1'b1 || data_o !== 16'sh1234)
            $display("FAIL depth0 w=%0d i=%0d vld_o=%b data_o=%h exp=1 1234", w, i, vld_o, data_o);
          else pass_cnt++;
        end
        drive(i < 10, 1'b1, 16'h8000, 8'h00, 2'(w), 16'sh1234);
      end
    end
  endtask

  task automatic test_square;
    logic signed [15:0] ex;
    do_reset();
    for (int i = 0; i < 1033; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        ex = ((i - 3) % 512 < 256) ? 16'sh4000 : 16'sh0040;
        total_cnt++;
        if (vld_o !== 1'b1 || data_o !== ex)
          $display("FAIL square n=%0d vld_o=%b data_o=%h exp=%h", i - 3, vld_o, data_o, ex);
        else pass_cnt++;
      end
      drive(i < 1030, 1'b1, 16'h8000, 8'hff, 2'd1, 16'sh4000);
    end
  endtask

  task automatic test_triangle;
    int idx [8] = '{0, 1, 128, 255, 256, 511, 512, 513};
    int ex  [8] = '{-64, -128, -8256, -16384, -16384, -64, -64, -128};
    do_reset();
    for (int i = 0; i < 523; i++) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        if (i - 3 == idx[k]) begin
          total_cnt++;
          if (vld_o !== 1'b1 || data_o !== 16'(ex[k]))
            $display("FAIL triangle n=%0d data_o=%0d exp=%0d", idx[k], data_o, ex[k]);
          else pass_cnt++;
        end
      end
      drive(i < 520, 1'b1, 16'h8000, 8'hff, 2'd0, -16'sd16384);
    end
  endtask

  task automatic test_floor;
    int din [5] = '{-1, 100, -300, 32767, -32768};
    int ex  [5] = '{-1, 0, -2, 127, -128};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        total_cnt++;
        if (data_o !== 16'(ex[i-3]))
          $display("FAIL floor n=%0d data_o=%0d exp=%0d", i - 3, data_o, ex[i-3]);
        else pass_cnt++;
      end
      drive(i < 5, 1'b1, 16'h0, 8'hff, 2'd0, (i < 5) ? 16'(din[i]) : 16'sh0);
    end
  endtask

  task automatic test_en_toggle;
    logic ens [7] = '{1, 1, 0, 1, 1, 1, 1};
    logic vls [7] = '{1, 1, 1, 1, 1, 0, 1};
    int   ex  [7] = '{-64, -128, -16384, -64, -128, -192, -192};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        total_cnt++;
        if (vld_o !== vls[i-3] || data_o !== 16'(ex[i-3]))
          $display("FAIL en_toggle n=%0d vld_o=%b data_o=%0d exp=%b %0d",
                   i - 3, vld_o, data_o, vls[i-3], ex[i-3]);
        else pass_cnt++;
      end
      if (i < 7) drive(vls[i], ens[i], 16'h8000, 8'hff, 2'd0, -16'sd16384);
      else       drive(1'b0, 1'b1, 16'h8000, 8'hff, 2'd0, -16'sd16384);
    end
  endtask

  task automatic test_sel2;
`ifdef EFF_TREMOLO_SINE_EN
    int ex0 = -8256;
    int ex128 = -16384;
`else
    int ex0 = -64;
    int ex128 = -8256;
`endif
    do_reset();
    for (int i = 0; i < 134; i++) begin
      @(negedge clk);
      if (i == 3) begin
        total_cnt++;
        if (data_o !== 16'(ex0)) $display("FAIL sel2 n=0 data_o=%0d exp=%0d", data_o, ex0);
        else pass_cnt++;
      end
      if (i == 131) begin
        total_cnt++;
        if (data_o !== 16'(ex128)) $display("FAIL sel2 n=128 data_o=%0d exp=%0d", data_o, ex128);
        else pass_cnt++;
      end
      drive(i < 131, 1'b1, 16'h8000, 8'hff, 2'd2, -16'sd16384);
    end
  endtask

  task automatic test_reset_mid;
    logic ev;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        ev = (i == 3) || (i == 10);
        total_cnt++;
        if (vld_o !== ev) $display("FAIL rst_mid_vld i=%0d vld_o=%b exp=%b", i, vld_o, ev);
        else pass_cnt++;
      end
      if (i == 3 || i == 10) begin
        total_cnt++;
        if (data_o !== 16'sh1234) $display("FAIL rst_mid_out i=%0d data_o=%h exp=1234", i, data_o);
        else pass_cnt++;
      end
      if (i == 4) begin
        total_cnt++;
        if (data_o !== 16'sh0) $display("FAIL rst_mid_clr data_o=%h exp=0000", data_o);
        else pass_cnt++;
      end
      rst = (i == 3);
      drive(i < 4 || i == 7, 1'b1, 16'h8000, 8'h00, 2'd0, 16'sh1234);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 8'h0, 2'd0, 16'sh0);
    test_reset();
    test_bypass();
    test_depth0();
    test_square();
    test_triangle();
    test_floor();
    test_en_toggle();
    test_sel2();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
